// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the 2-input gate truth-table sweeper.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int             VEC_W    = 2;
    localparam logic [VEC_W-1:0] LAST_VEC = 2'b11;

    // Reference behaviour of the gate under test: 2-input NOR of {a,b}.
    function automatic logic nor_expected(input logic [VEC_W-1:0] v);
        return ~(v[1] | v[0]);
    endfunction

endpackage

// File: rtl/gate_sweep_timer.sv
// Loadable down-counter timing the settle interval of each vector.
module gate_sweep_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives a 2-input gate through its truth table, samples the output after a
// settle interval and records mismatch count, first failing vector and verdict.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int N_PASSES      = 1,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       first_fail,
    output logic             first_fail_valid
);

    localparam int TMR_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
    localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(N_PASSES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VEC_W-1:0]   r_vec;
    logic [PASS_W-1:0]  r_pass_idx;
    logic [CNT_W-1:0]   r_err_count;
    logic [1:0]         r_first_fail;
    logic               r_first_fail_valid;
    logic               r_pass;
    logic               w_timer_load;
    logic               w_timer_zero;
    logic               w_mismatch;
    logic               w_last;

    gate_sweep_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_timer_load),
        .i_load_val (SETTLE_LOAD),
        .o_zero     (w_timer_zero)
    );

    assign w_mismatch = (r_state == SAMPLE) && (y != nor_expected(r_vec));
    assign w_last     = (r_vec == LAST_VEC) && (r_pass_idx == LAST_PASS);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; the settle timer reloads whenever a vector is launched.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt  = SETTLE;
                    w_timer_load = 1'b1;
                end
            end
            SETTLE: begin
                if (w_timer_zero) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (w_last) begin
                    w_state_nxt = FINISH;
                end else begin
                    w_state_nxt  = SETTLE;
                    w_timer_load = 1'b1;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Vector sequencing and result capture; results hold until the next start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec              <= '0;
            r_pass_idx         <= '0;
            r_err_count        <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_vec              <= '0;
            r_pass_idx         <= '0;
            r_err_count        <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
        end else if (r_state == SAMPLE) begin
            if (w_mismatch) begin
                if (r_err_count != CNT_MAX) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
                if (!r_first_fail_valid) begin
                    r_first_fail       <= r_vec;
                    r_first_fail_valid <= 1'b1;
                end
            end
            // Verdict is registered here so it is valid alongside done.
            if (w_last) begin
                r_pass <= (r_err_count == '0) && !w_mismatch;
            end else begin
                r_vec <= r_vec + VEC_W'(1);
                if (r_vec == LAST_VEC) begin
                    r_pass_idx <= r_pass_idx + PASS_W'(1);
                end
            end
        end
    end

    assign a                = r_vec[1];
    assign b                = r_vec[0];
    assign busy             = (r_state == SETTLE) || (r_state == SAMPLE);
    assign done             = (r_state == FINISH);
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail       = r_first_fail;
    assign first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: default instance plus a 3-pass, 2-bit counter instance.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0;
    logic start3 = 1'b0;

    logic       a0, b0, y0, busy0, done0, pass0, ffv0;
    logic [3:0] err0;
    logic [1:0] ff0;
    logic       a3, b3, y3, busy3, done3, pass3, ffv3;
    logic [1:0] err3;
    logic [1:0] ff3;

    // 0: correct NOR gate, 1: stuck-at-0, 2: inverted (OR)
    int mode0 = 0;
    int mode3 = 0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cycles;
        logic [3:0] err;
        logic [1:0] ff;
        logic       ffv;
        logic       pss;
    } res_t;

    res_t       sb[$];
    logic [1:0] vec_q[$];

    always #5 clk = ~clk;

    function automatic logic gate_model(input int m, input logic ga, input logic gb);
        if (m == 0) return ~(ga | gb);
        else if (m == 1) return 1'b0;
        else return ga | gb;
    endfunction

    assign y0 = gate_model(mode0, a0, b0);
    assign y3 = gate_model(mode3, a3, b3);

    gate_sweep_checker #(.SETTLE_CYCLES(4), .N_PASSES(1), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail(ff0), .first_fail_valid(ffv0)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(4), .N_PASSES(3), .CNT_W(2)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .a(a3), .b(b3), .y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail(ff3), .first_fail_valid(ffv3)
    );

    // Pulse start for one edge (edge E); returns just after E.
    task automatic pulse_start(input int sel);
        if (sel == 0) start0 = 1'b1; else start3 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start3 = 1'b0;
    endtask

    // Waits for done; cyc = edges after E at which done was seen, -1 on timeout.
    task automatic wait_done(input int sel, input int limit, output int cyc);
        int j;
        cyc = -1;
        j = 0;
        while (cyc < 0 && j < limit) begin
            @(posedge clk); #1;
            j++;
            if ((sel == 0 && done0 === 1'b1) || (sel == 3 && done3 === 1'b1)) cyc = j;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a0, b0, busy0, done0, pass0, err0, ff0, ffv0} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_dut0: got %b required 0", {a0, b0, busy0, done0, pass0, err0, ff0, ffv0});
        end
        n_checks++;
        if ({a3, b3, busy3, done3, pass3, err3, ff3, ffv3} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_dut3: got %b required 0", {a3, b3, busy3, done3, pass3, err3, ff3, ffv3});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        res_t       r;
        logic [1:0] ev;
        mode0 = 0;
        for (int j = 0; j < 20; j++) vec_q.push_back(2'(j / 5));
        sb.push_back('{cycles: 20, err: 4'd0, ff: 2'b00, ffv: 1'b0, pss: 1'b1});
        pulse_start(0);
        for (int j = 0; j < 20; j++) begin
            ev = vec_q.pop_front();
            n_checks++;
            if ({busy0, done0, a0, b0} !== {1'b1, 1'b0, ev}) begin
                n_fail++;
                $display("FAIL nominal_vec[%0d]: busy/done/a/b got %b required %b", j, {busy0, done0, a0, b0}, {2'b10, ev});
            end
            @(posedge clk); #1;
        end
        r = sb.pop_front();
        n_checks++;
        if ({done0, busy0} !== 2'b10) begin
            n_fail++;
            $display("FAIL nominal_done_cycle%0d: done/busy got %b required 10", r.cycles, {done0, busy0});
        end
        n_checks++;
        if ({err0, ff0, ffv0, pass0} !== {r.err, r.ff, r.ffv, r.pss}) begin
            n_fail++;
            $display("FAIL nominal_result: err/ff/ffv/pass got %h/%b/%b/%b required %h/%b/%b/%b",
                     err0, ff0, ffv0, pass0, r.err, r.ff, r.ffv, r.pss);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({done0, busy0, a0, b0, pass0} !== 5'b00111) begin
            n_fail++;
            $display("FAIL nominal_hold: done/busy/a/b/pass got %b required 00111", {done0, busy0, a0, b0, pass0});
        end
    endtask

    task automatic test_fault(input int m, input int sel, input res_t exp_r, input string nm);
        res_t r;
        int   cyc;
        if (sel == 0) mode0 = m; else mode3 = m;
        sb.push_back(exp_r);
        pulse_start(sel);
        wait_done(sel, 200, cyc);
        r = sb.pop_front();
        n_checks++;
        if (cyc != r.cycles) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d required %0d", nm, cyc, r.cycles);
        end
        if (sel == 0) begin
            n_checks++;
            if ({err0, ff0, ffv0, pass0} !== {r.err, r.ff, r.ffv, r.pss}) begin
                n_fail++;
                $display("FAIL %s_result: err/ff/ffv/pass got %h/%b/%b/%b required %h/%b/%b/%b",
                         nm, err0, ff0, ffv0, pass0, r.err, r.ff, r.ffv, r.pss);
            end
        end else begin
            n_checks++;
            if ({2'b00, err3, ff3, ffv3, pass3} !== {r.err, r.ff, r.ffv, r.pss}) begin
                n_fail++;
                $display("FAIL %s_result: err/ff/ffv/pass got %h/%b/%b/%b required %h/%b/%b/%b",
                         nm, err3, ff3, ffv3, pass3, r.err, r.ff, r.ffv, r.pss);
            end
        end
        @(posedge clk); #1;
        mode0 = 0;
        mode3 = 0;
    endtask

    task automatic test_reset_mid();
        int dones;
        int cyc;
        res_t r;
        mode0 = 2;
        pulse_start(0);
        repeat (6) begin @(posedge clk); #1; end
        n_checks++;
        if ({busy0, err0} !== 5'b1_0001) begin
            n_fail++;
            $display("FAIL midreset_pre: busy/err got %b required 10001", {busy0, err0});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({busy0, done0, a0, b0, err0, ffv0} !== 9'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: busy/done/a/b/err/ffv got %b required 0", {busy0, done0, a0, b0, err0, ffv0});
        end
        dones = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d done pulses required 0", dones);
        end
        mode0 = 0;
        sb.push_back('{cycles: 20, err: 4'd0, ff: 2'b00, ffv: 1'b0, pss: 1'b1});
        pulse_start(0);
        wait_done(0, 200, cyc);
        r = sb.pop_front();
        n_checks++;
        if (cyc != r.cycles || pass0 !== r.pss || err0 !== r.err || ffv0 !== r.ffv) begin
            n_fail++;
            $display("FAIL midreset_resweep: cycle/pass/err/ffv got %0d/%b/%h/%b required %0d/%b/%h/%b",
                     cyc, pass0, err0, ffv0, r.cycles, r.pss, r.err, r.ffv);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int         ph;
        int         dones;
        logic [3:0] exp_sig;
        res_t       r;
        mode0 = 0;
        start0 = 1'b1;
        for (int s = 0; s < 3; s++)
            sb.push_back('{cycles: 20, err: 4'd0, ff: 2'b00, ffv: 1'b0, pss: 1'b1});
        @(posedge clk); #1;
        dones = 0;
        for (int j = 0; j < 66; j++) begin
            ph = j % 22;
            if (ph < 20)       exp_sig = {2'b10, 2'(ph / 5)};
            else if (ph == 20) exp_sig = 4'b0111;
            else               exp_sig = 4'b0011;
            n_checks++;
            if ({busy0, done0, a0, b0} !== exp_sig) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: busy/done/a/b got %b required %b", j, {busy0, done0, a0, b0}, exp_sig);
            end
            if (done0 === 1'b1 && sb.size() > 0) begin
                r = sb.pop_front();
                dones++;
                n_checks++;
                if ({pass0, err0} !== {r.pss, r.err}) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: pass/err got %b/%h required %b/%h", dones, pass0, err0, r.pss, r.err);
                end
            end
            if (j == 65) start0 = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (dones != 3 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: dones/busy got %0d/%b required 3/0", dones, busy0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_fault(1, 0, '{cycles: 20, err: 4'd1, ff: 2'b00, ffv: 1'b1, pss: 1'b0}, "stuck0");
        test_fault(2, 0, '{cycles: 20, err: 4'd4, ff: 2'b00, ffv: 1'b1, pss: 1'b0}, "inverted");
        test_fault(2, 3, '{cycles: 60, err: 4'd3, ff: 2'b00, ffv: 1'b1, pss: 1'b0}, "saturate");
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-contained truth-table sweeper for a 2-input combinational gate such as the existing nor_gate.
- Drives the gate inputs (a, b) through all four vectors, waits a settle interval and samples the gate output.
- Compares each sample against the expected NOR value; reports a pass/fail verdict, a mismatch count and the first failing vector.
- Sits directly upstream (stimulus) and downstream (checker) of the gate, for on-chip self-test.

Parameters:
- SETTLE_CYCLES, 4: cycles each vector is driven before the output is sampled; legal range ≥1.
- N_PASSES, 1: number of complete 4-vector sweeps per start; legal range ≥1.
- CNT_W, 4: width of the mismatch counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- a  output  1  gate input A; MSB of the vector.
- b  output  1  gate input B; LSB of the vector.
- y  input  1  gate output under test.
- busy  output  1  high while in SETTLE or SAMPLE.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  high when the completed sweep had zero mismatches.
- err_count  output  CNT_W  mismatch count, saturating.
- first_fail  output  2  {a,b} of the first mismatch.
- first_fail_valid  output  1  high when first_fail holds a captured vector.

Behaviour:
- Reset: all outputs 0 (a, b, busy, done, pass, err_count, first_fail, first_fail_valid); state IDLE; vector index 0; pass index 0. Reset mid-sweep aborts immediately: no done pulse, all results cleared.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE, start=1 at edge E:
  - vector := 00; {a,b} := 00; settle count := SETTLE_CYCLES-1.
  - err_count, first_fail, first_fail_valid and pass cleared.
  - Next state SETTLE; busy=1 from the cycle after E.
- SETTLE:
  - count==0 -> SAMPLE; otherwise count decrements.
  - The vector is stable on a/b for exactly SETTLE_CYCLES cycles before SAMPLE.
- SAMPLE (one cycle):
  - Expected value = ~(a|b); y is compared during this cycle.
  - On mismatch: err_count increments, saturating at 2^CNT_W-1. If first_fail_valid==0, capture first_fail := {a,b} and set first_fail_valid := 1.
  - If vector==11 and pass index==N_PASSES-1 -> FINISH.
  - Otherwise the vector increments (11 wraps to 00 and the pass index increments), settle count reloads and the state returns to SETTLE.
- FINISH (one cycle): done=1, busy=0, pass := (err_count==0 and no mismatch in the final sample). Next state IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done is high in the cycle after edge E + 4·N_PASSES·(SETTLE_CYCLES+1).
- Hold behaviour: a, b hold the last driven vector (11). err_count, pass, first_fail and first_fail_valid hold until the next accepted start.
- start in SETTLE, SAMPLE or FINISH is ignored. If start is still high in the IDLE cycle after FINISH, a new sweep begins.
- Error count saturation: the counter never wraps.

Decomposition:
- Package gate_sweep_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, FINISH);
  - VEC_W=2 and LAST_VEC=2'b11;
  - expected-output function (2-input NOR).
- One natural sub-module, gate_sweep_timer:
  - loadable down-counter of width clog2(SETTLE_CYCLES);
  - load/zero interface used for the settle interval.
- Vector sequencing, compare and result registers stay in the top level.

Test Plan:
- nor_gate wired to a/b/y, defaults, 1-cycle start pulse -> {a,b} shows 00, 01, 10, 11 for 5 cycles each; done high in cycle 20 after the start edge; pass=1, err_count=0, first_fail_valid=0.
- y tied 0 (stuck-at-0 gate) -> err_count=1, first_fail=00, first_fail_valid=1, pass=0.
- y = a|b (inverted gate model) -> err_count=4, first_fail=00, pass=0.
- N_PASSES=3, CNT_W=2, y = a|b -> 12 raw mismatches; err_count saturates at 3; done in cycle 60; pass=0.
- reset asserted in cycle 7 of a sweep -> next cycle busy=0, a=b=0, err_count=0; no done pulse; a following start produces a clean 20-cycle sweep with pass=1.
- start held high continuously -> exactly one done per sweep; the next sweep begins in the IDLE cycle after FINISH; start during busy never restarts the vector sequence.
